// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and helpers for the instruction/data memory arbiter.
//  arb_state_t  arbiter FSM states
//  arb_src_t    requester that won arbitration
//  BE_ALL       full-word byte enable used by instruction fetches
//  bswap32      reverses the byte order of a 32-bit word
package mips_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_RESP_I = 3'd3,
    ST_RESP_D = 3'd4
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: Avalon-style single-port memory bus.
//  m_address/m_read/m_write/m_writedata/m_byteenable  master -> slave
//  m_waitrequest/m_readdata                            slave -> master
interface mips_mem_arbiter_if;

  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;

  modport master (
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata
  );

  modport slave (
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata
  );

endinterface

// File: rtl/mips_mem_arbiter_byte_swap.sv
// mips_byte_swap: endianness adapter between the big-endian core and the memory.
//  data_i/be_i  word and byte enables in one byte order
//  data_o/be_o  same word and byte enables, reversed when MIPS_ARB_BYTESWAP_EN
//               is defined, passed through unchanged otherwise
module mips_byte_swap
  import mips_mem_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [3:0]  be_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o
);

`ifdef MIPS_ARB_BYTESWAP_EN
  assign data_o = bswap32(data_i);
  assign be_o   = {be_i[0], be_i[1], be_i[2], be_i[3]};
`else
  assign data_o = data_i;
  assign be_o   = be_i;
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory port between the instruction-fetch and
// data requesters, one transaction outstanding at a time. Data wins by default;
// after STARVE_LIMIT consecutive data grants with a fetch pending, the fetch is
// forced through.
//  clk, reset                 clock, synchronous active-high reset
//  i_req_i/i_addr_i           fetch request and byte address
//  i_gnt_o/i_done_o/i_rdata_o fetch captured / data valid / fetch data
//  d_req_i/d_we_i/d_addr_i/d_wdata_i/d_be_i  data request fields
//  d_gnt_o/d_done_o/d_rdata_o data captured / complete / read data
//  mem                        memory bus (master side), all outputs registered
// Build option: MIPS_ARB_BYTESWAP_EN reverses byte order of write data, byte
// enables and read data between core and memory.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 2,
  parameter int unsigned CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_done_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_be_i,
  output logic        d_gnt_o,
  output logic        d_done_o,
  output logic [31:0] d_rdata_o,
  mips_mem_arbiter_if.master mem
);

  localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  arb_state_t       state_q;
  logic [CNT_W-1:0] starve_cnt_q;
  logic [31:0]      m_address_q;
  logic             m_read_q;
  logic             m_write_q;
  logic [31:0]      m_writedata_q;
  logic [3:0]       m_byteenable_q;

  logic             arb_en_s;
  logic             starve_hit_s;
  logic             grant_vld_s;
  arb_src_t         grant_src_s;
  logic [31:0]      wr_data_sw_s;
  logic [3:0]       wr_be_sw_s;
  logic [31:0]      rd_data_sw_s;
  logic [3:0]       unused_rd_be_s;

  mips_byte_swap u_wr_swap (
    .data_i (d_wdata_i),
    .be_i   (d_be_i),
    .data_o (wr_data_sw_s),
    .be_o   (wr_be_sw_s)
  );

  // Read path only needs the data half of the swapper.
  mips_byte_swap u_rd_swap (
    .data_i (mem.m_readdata),
    .be_i   (4'h0),
    .data_o (rd_data_sw_s),
    .be_o   (unused_rd_be_s)
  );

  // Arbitration: only in IDLE or a response cycle, so a new grant can overlap done.
  always_comb begin
    arb_en_s     = 1'b0;
    starve_hit_s = (starve_cnt_q == LIMIT_C);
    case (state_q)
      ST_IDLE, ST_RESP_I, ST_RESP_D: arb_en_s = 1'b1;
      default:                       arb_en_s = 1'b0;
    endcase
    grant_vld_s = arb_en_s && !reset && (i_req_i || d_req_i);
    if (i_req_i && (!d_req_i || starve_hit_s)) begin
      grant_src_s = SRC_I;
    end else begin
      grant_src_s = SRC_D;
    end
  end

  assign i_gnt_o   = grant_vld_s && (grant_src_s == SRC_I);
  assign d_gnt_o   = grant_vld_s && (grant_src_s == SRC_D);
  assign i_done_o  = (state_q == ST_RESP_I);
  assign d_done_o  = (state_q == ST_RESP_D);
  assign i_rdata_o = rd_data_sw_s;
  assign d_rdata_o = rd_data_sw_s;

  assign mem.m_address    = m_address_q;
  assign mem.m_read       = m_read_q;
  assign mem.m_write      = m_write_q;
  assign mem.m_writedata  = m_writedata_q;
  assign mem.m_byteenable = m_byteenable_q;

  // FSM, starvation counter and registered memory-bus fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      starve_cnt_q   <= '0;
      m_address_q    <= 32'h0;
      m_read_q       <= 1'b0;
      m_write_q      <= 1'b0;
      m_writedata_q  <= 32'h0;
      m_byteenable_q <= 4'h0;
    end else begin
      case (state_q)
        ST_BUSY_I: begin
          if (!mem.m_waitrequest) begin
            state_q  <= ST_RESP_I;
            m_read_q <= 1'b0;
          end
        end
        ST_BUSY_D: begin
          if (!mem.m_waitrequest) begin
            state_q   <= ST_RESP_D;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
          end
        end
        // IDLE, RESP_* and any illegal encoding arbitrate for the next request.
        default: begin
          if (i_gnt_o) begin
            state_q        <= ST_BUSY_I;
            m_read_q       <= 1'b1;
            m_write_q      <= 1'b0;
            m_address_q    <= i_addr_i;
            m_byteenable_q <= BE_ALL;
            starve_cnt_q   <= '0;
          end else if (d_gnt_o) begin
            state_q        <= ST_BUSY_D;
            m_read_q       <= !d_we_i;
            m_write_q      <= d_we_i;
            m_address_q    <= d_addr_i;
            m_writedata_q  <= wr_data_sw_s;
            m_byteenable_q <= wr_be_sw_s;
            if (i_req_i && (starve_cnt_q != CNT_MAX_C)) begin
              starve_cnt_q <= starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed bench for mips_mem_arbiter with hand-computed
// expectations. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

`ifdef MIPS_ARB_BYTESWAP_EN
  localparam logic [31:0] FETCH_MEM = 32'h05000224;
  localparam logic [31:0] WR_MEM    = 32'hEFBEADDE;
  localparam logic [3:0]  WBE_MEM   = 4'hC;
  localparam logic [3:0]  RBE_MEM   = 4'h8;
  localparam logic [31:0] RD0_MEM   = 32'h44332211;
  localparam logic [31:0] RD1_MEM   = 32'hD8C7B6A5;
`else
  localparam logic [31:0] FETCH_MEM = 32'h24020005;
  localparam logic [31:0] WR_MEM    = 32'hDEADBEEF;
  localparam logic [3:0]  WBE_MEM   = 4'h3;
  localparam logic [3:0]  RBE_MEM   = 4'h1;
  localparam logic [31:0] RD0_MEM   = 32'h11223344;
  localparam logic [31:0] RD1_MEM   = 32'hA5B6C7D8;
`endif

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;

  int n_chk;
  int n_bad;

  mips_mem_arbiter_if mem_if();

  mips_mem_arbiter #(.STARVE_LIMIT(2), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req_i   (i_req),
    .i_addr_i  (i_addr),
    .i_gnt_o   (i_gnt),
    .i_done_o  (i_done),
    .i_rdata_o (i_rdata),
    .d_req_i   (d_req),
    .d_we_i    (d_we),
    .d_addr_i  (d_addr),
    .d_wdata_i (d_wdata),
    .d_be_i    (d_be),
    .d_gnt_o   (d_gnt),
    .d_done_o  (d_done),
    .d_rdata_o (d_rdata),
    .mem       (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_g;
    logic [3:0] order;
    logic seen_done;
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    mem_if.m_waitrequest = 1'b0;
    mem_if.m_readdata    = 32'h0;
    tick(); tick();
    @(negedge clk);
    chk("rst_m_read",  32'(mem_if.m_read), 32'd0);
    chk("rst_m_write", 32'(mem_if.m_write), 32'd0);
    chk("rst_m_addr",  mem_if.m_address, 32'h0);
    chk("rst_m_wdata", mem_if.m_writedata, 32'h0);
    chk("rst_m_be",    32'(mem_if.m_byteenable), 32'h0);
    chk("rst_done",    32'({i_done, d_done, i_gnt, d_gnt}), 32'h0);

    // Fetch, zero wait: gnt c0, strobe c1, done c2.
    tick();
    reset = 1'b0; i_req = 1'b1; i_addr = 32'hBFC00000;
    @(negedge clk);
    chk("f_gnt_c0",  32'(i_gnt), 32'd1);
    chk("f_read_c0", 32'(mem_if.m_read), 32'd0);
    tick();
    i_req = 1'b0; mem_if.m_readdata = FETCH_MEM;
    @(negedge clk);
    chk("f_read_c1", 32'(mem_if.m_read), 32'd1);
    chk("f_addr_c1", mem_if.m_address, 32'hBFC00000);
    chk("f_be_c1",   32'(mem_if.m_byteenable), 32'hF);
    chk("f_done_c1", 32'(i_done), 32'd0);
    tick();
    @(negedge clk);
    chk("f_done_c2",  32'(i_done), 32'd1);
    chk("f_rdata_c2", i_rdata, 32'h24020005);
    chk("f_read_c2",  32'(mem_if.m_read), 32'd0);
    tick();
    @(negedge clk);
    chk("f_done_c3", 32'(i_done), 32'd0);

    // Data write with 3 wait cycles: m_write held 4 cycles.
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_be = 4'h3;
    mem_if.m_waitrequest = 1'b1;
    @(negedge clk);
    chk("w_gnt", 32'(d_gnt), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      d_req = 1'b0;
      if (c == 3) mem_if.m_waitrequest = 1'b0;
      @(negedge clk);
      chk("w_write_held", 32'(mem_if.m_write), 32'd1);
      chk("w_no_done",    32'(d_done), 32'd0);
    end
    chk("w_addr",  mem_if.m_address, 32'h1000);
    chk("w_wdata", mem_if.m_writedata, WR_MEM);
    chk("w_be",    32'(mem_if.m_byteenable), 32'(WBE_MEM));
    tick();
    @(negedge clk);
    chk("w_done",     32'(d_done), 32'd1);
    chk("w_write_lo", 32'(mem_if.m_write), 32'd0);
    tick();
    @(negedge clk);
    chk("w_done_end", 32'(d_done), 32'd0);

    // Starvation: both requesting, expect grants D,D,I,D.
    tick();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    n_g = 0;
    order = 4'h0;
    for (int c = 0; c < 40 && n_g < 4; c++) begin
      @(negedge clk);
      chk("s_gnt_excl", 32'(i_gnt & d_gnt), 32'd0);
      chk("s_strb_excl", 32'(mem_if.m_read & mem_if.m_write), 32'd0);
      if (i_gnt || d_gnt) begin
        order[n_g] = i_gnt;
        n_g++;
      end
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("s_grant_cnt",   32'(n_g), 32'd4);
    chk("s_grant_order", 32'(order), 32'h4);
    tick(); tick(); tick();

    // Reset during a stalled write: strobe drops, no done pulse.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'h0; d_be = 4'hF;
    mem_if.m_waitrequest = 1'b1;
    @(negedge clk);
    chk("r_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    chk("r_write_busy", 32'(mem_if.m_write), 32'd1);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("r_write_lo", 32'(mem_if.m_write), 32'd0);
    chk("r_addr_clr", mem_if.m_address, 32'h0);
    reset = 1'b0;
    mem_if.m_waitrequest = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      seen_done = seen_done | d_done;
    end
    chk("r_no_done", 32'(seen_done), 32'd0);
    tick();
    i_req = 1'b1; i_addr = 32'h200;
    @(negedge clk);
    chk("r_idle_gnt", 32'(i_gnt), 32'd1);
    tick();
    i_req = 1'b0;
    tick(); tick();

    // Back-to-back data reads: second grant coincides with first done.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_be = 4'h1;
    @(negedge clk);
    chk("b_gnt0", 32'(d_gnt), 32'd1);
    tick();
    d_addr = 32'h4; d_be = 4'hF; mem_if.m_readdata = RD0_MEM;
    @(negedge clk);
    chk("b_busy_nognt", 32'(d_gnt), 32'd0);
    chk("b_read0",      32'(mem_if.m_read), 32'd1);
    chk("b_addr0",      mem_if.m_address, 32'h0);
    chk("b_be0",        32'(mem_if.m_byteenable), 32'(RBE_MEM));
    tick();
    @(negedge clk);
    chk("b_done0",  32'(d_done), 32'd1);
    chk("b_rdata0", d_rdata, 32'h11223344);
    chk("b_gnt1",   32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0; mem_if.m_readdata = RD1_MEM;
    @(negedge clk);
    chk("b_read1", 32'(mem_if.m_read), 32'd1);
    chk("b_addr1", mem_if.m_address, 32'h4);
    tick();
    @(negedge clk);
    chk("b_done1",  32'(d_done), 32'd1);
    chk("b_rdata1", d_rdata, 32'hA5B6C7D8);
    tick();
    @(negedge clk);
    chk("b_idle", 32'({d_done, mem_if.m_read}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
